// File: rtl/player_move_scheduler.sv
// player_move_scheduler: per-tick movement sequencing for two players that share a single
// map-RAM read port, plus a round-robin bomb-placement request arbiter.
// Optional feature macro: PLAYER_COLLIDE_EN. When defined, a move onto the other
// player's current cell is rejected. When undefined, only the map tile gates movement.
// Each served slot costs ADDR, WAIT, CHECK, NEXT when a RAM read is needed, or ADDR and
// NEXT when the move is absent or off-grid. A position commits on the CHECK edge.
module player_move_scheduler #(
  parameter int unsigned GRID_W  = 15,
  parameter int unsigned GRID_H  = 13,
  parameter int unsigned COORD_W = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned P1_X0   = 1,
  parameter int unsigned P1_Y0   = 1,
  parameter int unsigned P2_X0   = 13,
  parameter int unsigned P2_Y0   = 11
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               tick,
  input  logic               p1_bomb,
  input  logic               p1_xdir,
  input  logic               p1_ydir,
  input  logic               p1_x_mov,
  input  logic               p1_y_mov,
  input  logic               p2_bomb,
  input  logic               p2_xdir,
  input  logic               p2_ydir,
  input  logic               p2_x_mov,
  input  logic               p2_y_mov,
  output logic [ADDR_W-1:0]  map_addr,
  input  logic [1:0]         map_rdata,
  output logic [COORD_W-1:0] p1_x,
  output logic [COORD_W-1:0] p1_y,
  output logic [COORD_W-1:0] p2_x,
  output logic [COORD_W-1:0] p2_y,
  output logic               bomb_valid,
  output logic               bomb_player,
  output logic [COORD_W-1:0] bomb_x,
  output logic [COORD_W-1:0] bomb_y,
  input  logic               bomb_ready,
  output logic               busy
);

  typedef enum logic [2:0] {StIdle, StAddr, StWait, StCheck, StNext} state_e;

  // Move sequencer state. Index 0 of every pair belongs to P1, index 1 to P2.
  state_e                    state_q;
  logic                      slot_q;
  logic                      first_slot_q;
  logic [1:0]                xdir_q, ydir_q, xmov_q, ymov_q;
  logic [1:0][COORD_W-1:0]   pos_x_q, pos_y_q;
  logic [COORD_W-1:0]        tgt_x_q, tgt_y_q;
  logic [ADDR_W-1:0]         map_addr_q;

  // Bomb arbiter state.
  logic [1:0]                pend_q;
  logic [1:0][COORD_W-1:0]   bx_q, by_q;
  logic                      last_valid_q, last_q;
  logic                      bomb_valid_q, bomb_player_q;
  logic [COORD_W-1:0]        bomb_x_q, bomb_y_q;

  // Combinational helpers.
  logic [COORD_W-1:0]        cur_x, cur_y, nxt_x, nxt_y;
  logic                      move_ok;
  logic [ADDR_W-1:0]         nxt_addr;
  logic                      collide;
  logic                      accept;
  logic                      handshake;
  logic [1:0]                pend_clr, pend_set;
  logic                      last_valid_d, last_d;
  logic                      grant_sel, present;

  assign accept = (state_q == StIdle) && tick;

  // Target cell for the player in the current slot, with grid-edge rejection.
  always_comb begin
    cur_x   = pos_x_q[slot_q];
    cur_y   = pos_y_q[slot_q];
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    move_ok = 1'b0;
    if (xmov_q[slot_q]) begin
      if (xdir_q[slot_q]) begin
        nxt_x   = cur_x + COORD_W'(1);
        move_ok = (cur_x < COORD_W'(GRID_W - 1));
      end else begin
        nxt_x   = cur_x - COORD_W'(1);
        move_ok = (cur_x != '0);
      end
    end else if (ymov_q[slot_q]) begin
      if (ydir_q[slot_q]) begin
        nxt_y   = cur_y + COORD_W'(1);
        move_ok = (cur_y < COORD_W'(GRID_H - 1));
      end else begin
        nxt_y   = cur_y - COORD_W'(1);
        move_ok = (cur_y != '0);
      end
    end
  end

  assign nxt_addr = ADDR_W'(nxt_y) * ADDR_W'(GRID_W) + ADDR_W'(nxt_x);

`ifdef PLAYER_COLLIDE_EN
  // The other player's position already reflects any commit made earlier in this tick.
  assign collide = (tgt_x_q == pos_x_q[~slot_q]) && (tgt_y_q == pos_y_q[~slot_q]);
`else
  assign collide = 1'b0;
`endif

  // Move FSM: snapshot controls on tick, then serve both slots through the shared RAM port.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= StIdle;
      slot_q       <= 1'b0;
      first_slot_q <= 1'b0;
      xdir_q       <= '0;
      ydir_q       <= '0;
      xmov_q       <= '0;
      ymov_q       <= '0;
      pos_x_q[0]   <= COORD_W'(P1_X0);
      pos_y_q[0]   <= COORD_W'(P1_Y0);
      pos_x_q[1]   <= COORD_W'(P2_X0);
      pos_y_q[1]   <= COORD_W'(P2_Y0);
      tgt_x_q      <= '0;
      tgt_y_q      <= '0;
      map_addr_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tick) begin
            xdir_q  <= {p2_xdir, p1_xdir};
            ydir_q  <= {p2_ydir, p1_ydir};
            xmov_q  <= {p2_x_mov, p1_x_mov};
            ymov_q  <= {p2_y_mov, p1_y_mov};
            slot_q  <= first_slot_q;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (move_ok) begin
            map_addr_q <= nxt_addr;
            tgt_x_q    <= nxt_x;
            tgt_y_q    <= nxt_y;
            state_q    <= StWait;
          end else begin
            state_q <= StNext;
          end
        end
        StWait: state_q <= StCheck;
        StCheck: begin
          if ((map_rdata == 2'd0) && !collide) begin
            pos_x_q[slot_q] <= tgt_x_q;
            pos_y_q[slot_q] <= tgt_y_q;
          end
          state_q <= StNext;
        end
        StNext: begin
          // Slot differs from first_slot only after the second player has been served.
          if (slot_q != first_slot_q) begin
            first_slot_q <= ~first_slot_q;
            state_q      <= StIdle;
          end else begin
            slot_q  <= ~slot_q;
            state_q <= StAddr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bomb arbiter next-state: retire the accepted request, pick the next one round-robin.
  always_comb begin
    handshake = bomb_valid_q & bomb_ready;
    pend_clr  = pend_q;
    if (handshake) pend_clr[bomb_player_q] = 1'b0;
    last_valid_d = last_valid_q | handshake;
    last_d       = handshake ? bomb_player_q : last_q;
    // With no grant history P1 wins a tie; afterwards the player not granted last wins.
    if (&pend_clr) grant_sel = last_valid_d ? ~last_d : 1'b0;
    else           grant_sel = pend_clr[1];
    present  = (|pend_clr) & (~bomb_valid_q | handshake);
    pend_set = accept ? ({p2_bomb, p1_bomb} & ~pend_q) : 2'b00;
  end

  // Bomb arbiter registers; runs regardless of the move FSM state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pend_q        <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      last_valid_q  <= 1'b0;
      last_q        <= 1'b0;
      bomb_valid_q  <= 1'b0;
      bomb_player_q <= 1'b0;
      bomb_x_q      <= '0;
      bomb_y_q      <= '0;
    end else begin
      pend_q       <= pend_clr | pend_set;
      last_valid_q <= last_valid_d;
      last_q       <= last_d;
      // Latch the pre-move cell; the move FSM commits no earlier than three edges later.
      for (int p = 0; p < 2; p++) begin
        if (pend_set[p]) begin
          bx_q[p] <= pos_x_q[p];
          by_q[p] <= pos_y_q[p];
        end
      end
      if (present) begin
        bomb_valid_q  <= 1'b1;
        bomb_player_q <= grant_sel;
        bomb_x_q      <= bx_q[grant_sel];
        bomb_y_q      <= by_q[grant_sel];
      end else if (handshake) begin
        bomb_valid_q <= 1'b0;
      end
    end
  end

  assign map_addr    = map_addr_q;
  assign p1_x        = pos_x_q[0];
  assign p1_y        = pos_y_q[0];
  assign p2_x        = pos_x_q[1];
  assign p2_y        = pos_y_q[1];
  assign bomb_valid  = bomb_valid_q;
  assign bomb_player = bomb_player_q;
  assign bomb_x      = bomb_x_q;
  assign bomb_y      = bomb_y_q;
  assign busy        = (state_q != StIdle);

endmodule
